// File: rtl/scan_pkg.sv
// scan_pkg: state encoding, synchroniser default and frame length shared by scan_responder.
// Macro SCAN_PARITY_EN lengthens every frame by one trailing even-parity bit.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic int frame_len(input int width);
`ifdef SCAN_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/scan_responder_if.sv
// scan_responder_if: serial scan lines between the scanchain controller (master)
// and the chain-side responder (slave).
interface scan_responder_if;

  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic rtck;

  modport master (output tck, output tms, output tdi, input tdo, input rtck);
  modport slave  (input tck, input tms, input tdi, output tdo, output rtck);

endinterface

// File: rtl/scan_sync_edge.sv
// scan_sync_edge: multi-stage synchroniser for an asynchronous level plus one-clk
// rise/fall pulses derived from the synchronised value.
module scan_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/scan_responder.sv
// scan_responder: chain-side scan endpoint that oversamples tck/tms/tdi on clk, captures
// i_data, shifts it out on tdo and updates o_data at frame end. Optional: SCAN_PARITY_EN.
module scan_responder
  import scan_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  scan_responder_if.slave  scan,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_err
);

  localparam int                FRAME_LEN = frame_len(WIDTH);
  localparam int                CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAME_LEN + 1);

  logic tck_sync, tck_rise, tck_fall;
  logic tms_sync, tms_rise, tms_fall;
  logic tdi_sync;
  logic [SYNC_STAGES-1:0] tdi_chain_q;

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tdo_q, tdo_d;
  logic                   rtck_q;
  logic [WIDTH-1:0]       odata_q, odata_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [FRAME_LEN-1:0]   capture_word;
  logic                   parity_ok;

  scan_sync_edge #(.STAGES(SYNC_STAGES)) u_tck_sync (
    .clk(clk), .reset(reset), .async_i(scan.tck),
    .sync_o(tck_sync), .rise_o(tck_rise), .fall_o(tck_fall)
  );

  scan_sync_edge #(.STAGES(SYNC_STAGES)) u_tms_sync (
    .clk(clk), .reset(reset), .async_i(scan.tms),
    .sync_o(tms_sync), .rise_o(tms_rise), .fall_o(tms_fall)
  );

  assign tdi_sync = tdi_chain_q[SYNC_STAGES-1];

`ifdef SCAN_PARITY_EN
  assign capture_word = {^i_data, i_data};
  assign parity_ok    = ~^shift_q;
`else
  assign capture_word = i_data;
  assign parity_ok    = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tdi_chain_q <= '0;
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      tdo_q       <= 1'b0;
      rtck_q      <= 1'b0;
      odata_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tdi_chain_q <= {tdi_chain_q[SYNC_STAGES-2:0], scan.tdi};
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tdo_q       <= tdo_d;
      rtck_q      <= tck_sync;
      odata_q     <= odata_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tdo_d   = tdo_q;
    odata_d = odata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tms_rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        shift_d = capture_word;
        tdo_d   = i_data[0];
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (tck_rise) begin
          shift_d = {tdi_sync, shift_q[FRAME_LEN-1:1]};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (tck_fall) begin
          tdo_d = shift_q[0];
        end
        // The level check also ends a frame whose tms dropped during the CAPTURE cycle.
        if (tms_fall || !tms_sync) state_d = UPDATE;
      end
      UPDATE: begin
        if (cnt_q == CNT_FULL && parity_ok) begin
          odata_d = shift_q[WIDTH-1:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan.tdo  = tdo_q;
  assign scan.rtck = rtck_q;
  assign o_data    = odata_q;
  assign o_valid   = valid_q;
  assign o_err     = err_q;

endmodule
